uart_arbiter: RTL and testbench
===============================

# uart_arbiter

Round-robin arbiter and sequencer that shares the single register port of `uart_model` between NREQ bus requesters, such as multiple processor cores or test masters. It serialises requests, drives the UART's cs/wr/rd strobes with registered timing, and waits for `rvalid` on reads. It returns data and a one-cycle acknowledge to the winning requester, and reports an error if a read is not answered within TIMEOUT cycles.

## Interface
- NREQ, 4: number of requesters (2..8)
- TIMEOUT, 16: max cycles to wait for uart_rvalid after a read strobe (1..255)
- clk  in  1  clock
- nreset  in  1  asynchronous, active-low reset
- req_cs  in  NREQ  per-requester select; held high until that requester's ack
- req_wr  in  NREQ  per-requester write
- req_rd  in  NREQ  per-requester read
- req_addr  in  5*NREQ  requester i address at [5i+4:5i]
- req_wdata  in  32*NREQ  requester i write data at [32i+31:32i]
- req_ack  out  NREQ  one-cycle completion pulse to the granted requester
- req_rdata  out  32  read data, valid while req_ack is high on a read
- req_err  out  1  high with req_ack when a read timed out
- gnt_idx  out  3  index of the current or last granted requester
- busy  out  1  high in any state other than IDLE
- uart_cs, uart_wr, uart_rd  out  1 each  registered strobes to uart_model
- uart_addr  out  5  registered address to uart_model
- uart_wdata  out  32  registered write data to uart_model
- uart_rdata  in  32  uart_model read data
- uart_rvalid  in  1  uart_model read valid

## Operation
- Request valid: req_cs[i] & (req_wr[i] | req_rd[i]). If both wr and rd are high, the request is a write only. A cs with neither is ignored.
- Round-robin:
  - Search starts at last_gnt+1, modulo NREQ.
  - last_gnt resets to NREQ-1, so requester 0 wins first.
  - last_gnt updates on each grant.
- State IDLE:
  - If any request is valid, latch the winner into gnt_idx.
  - Register uart_cs=1, uart_addr and uart_wdata from the winner, and uart_wr or uart_rd accordingly.
  - Go to WRITE or READ.
- WRITE (1 cycle): strobes are visible to uart_model. Clear the strobes and go to ACK.
- READ (1 cycle): uart_cs=uart_rd=1 visible. Clear the strobes, load the timeout counter with TIMEOUT, and go to WAIT.
- WAIT:
  - On uart_rvalid=1: capture uart_rdata into req_rdata, set err=0, go to ACK.
  - Otherwise, if the counter is 1: set req_rdata=32'hDEADBEEF, err=1, go to ACK.
  - Otherwise: decrement the counter and stay in WAIT.
- ACK (1 cycle):
  - req_ack[gnt_idx]=1, and req_err=err on reads (0 on writes).
  - Next state is REC.
- REC (1 cycle): recovery cycle, so the requester can drop req_cs before re-arbitration. Return to IDLE.
- Hold behaviour:
  - req_rdata holds its value until the next read completes.
  - gnt_idx holds until the next grant.
- Only one transaction is outstanding at a time. Requests that arrive mid-transaction wait, with no loss and no reorder within a requester.

## Timing
- Reset: state=IDLE, last_gnt=NREQ-1, and the following outputs are 0:
  - req_ack, req_err, req_rdata, gnt_idx
  - busy
  - uart_cs, uart_wr, uart_rd, uart_addr, uart_wdata
- Cycle counts below are relative to cycle 0, when the request is valid in IDLE.
- Write:
  - cycle 1: uart_cs/uart_wr high; uart_model prints at the end of cycle 1.
  - cycle 2: req_ack high.
  - cycle 3: REC.
  - cycle 4: the earliest next grant.
- Read:
  - cycle 1: uart_cs/uart_rd high.
  - cycle 2: uart_rvalid high, captured in WAIT.
  - cycle 3: req_ack and req_rdata valid.
  - cycle 4: REC.
- Timeout read: req_ack occurs TIMEOUT+2 cycles after cycle 0.
- busy is high from cycle 1 through REC inclusive.
- uart_rvalid seen outside WAIT is ignored.
- Requester dropping req_cs after grant: the transaction still completes and ack still pulses.
- Reset asserted mid-transaction: all outputs clear immediately (asynchronous), no ack is issued, the strobes drop, and arbitration restarts at requester 0.

## Test plan
- Single write: req 0 writes addr 5'h00, wdata 32'h41.
  - uart_cs/uart_wr high in cycle 1, "A" is printed.
  - req_ack=4'b0001 in cycle 2, req_err=0.
- Single read: req 2 reads addr 5'h14.
  - uart_rd is a one-cycle pulse.
  - req_ack=4'b0100 in cycle 3 with req_rdata=32'h20.
  - A follow-up read of 5'h00 returns 32'hcc.
- Round-robin fairness: all 4 requesters continuously write distinct chars.
  - Grants go 0,1,2,3,0.
  - Printed order matches, and each write completes in 4 cycles.
- Timeout: uart_rvalid is forced low, req 1 reads with TIMEOUT=16.
  - ack occurs on cycle 18 with req_err=1 and req_rdata=32'hDEADBEEF.
  - The next transaction proceeds normally.
- wr+rd together: req 3 drives both with addr 0, wdata 32'h42.
  - Only uart_wr is pulsed, "B" is printed, and req_err=0.
- Reset mid-read: nreset is pulled low during WAIT.
  - All outputs are 0 within the same cycle and no ack occurs.
  - After release, a req 0/req 3 contention grants req 0 first.

Source files
------------

// File: rtl/uart_arbiter.sv
// uart_arbiter
//
// Shares the single register port of a uart_model between NREQ bus
// requesters. Requests are granted round-robin, one transaction at a time.
// The UART strobes are registered. Reads wait for uart_rvalid, bounded by
// TIMEOUT cycles.
//
// Ports
//   clk, nreset        clock, asynchronous active-low reset
//   req_cs/wr/rd       per-requester select / write / read (NREQ bits each)
//   req_addr           requester i address at [5i+4:5i]
//   req_wdata          requester i write data at [32i+31:32i]
//   req_ack            one-cycle completion pulse to the granted requester
//   req_rdata          read data, held until the next read completes
//   req_err            read timed out (valid with req_ack)
//   gnt_idx            current / last granted requester
//   busy               transaction in flight (any state but IDLE)
//   uart_cs/wr/rd      registered strobes to uart_model
//   uart_addr/wdata    registered address / write data to uart_model
//   uart_rdata/rvalid  read return from uart_model
module uart_arbiter #(
  parameter int NREQ    = 4,
  parameter int TIMEOUT = 16
) (
  input  logic               clk,
  input  logic               nreset,
  input  logic [NREQ-1:0]    req_cs,
  input  logic [NREQ-1:0]    req_wr,
  input  logic [NREQ-1:0]    req_rd,
  input  logic [5*NREQ-1:0]  req_addr,
  input  logic [32*NREQ-1:0] req_wdata,
  output logic [NREQ-1:0]    req_ack,
  output logic [31:0]        req_rdata,
  output logic               req_err,
  output logic [2:0]         gnt_idx,
  output logic               busy,
  output logic               uart_cs,
  output logic               uart_wr,
  output logic               uart_rd,
  output logic [4:0]         uart_addr,
  output logic [31:0]        uart_wdata,
  input  logic [31:0]        uart_rdata,
  input  logic               uart_rvalid
);

  typedef enum logic [2:0] {
    S_IDLE, S_WRITE, S_READ, S_WAIT, S_ACK, S_REC
  } state_t;

  state_t          state_q, state_d;
  logic [2:0]      last_gnt_q, last_gnt_d;
  logic [2:0]      gnt_idx_q, gnt_idx_d;
  logic            cs_q, cs_d, wr_q, wr_d, rd_q, rd_d;
  logic [4:0]      addr_q, addr_d;
  logic [31:0]     wdata_q, wdata_d;
  logic [31:0]     rdata_q, rdata_d;
  logic [7:0]      cnt_q, cnt_d;
  logic            err_q, err_d;
  logic            is_rd_q, is_rd_d;

  logic [NREQ-1:0] req_vld;
  logic [NREQ-1:0] win_oh;
  logic            win_vld;
  logic [2:0]      win_idx;
  logic            win_wr;
  logic [4:0]      win_addr;
  logic [31:0]     win_wdata;

  // A cs with neither wr nor rd is not a request.
  assign req_vld = req_cs & (req_wr | req_rd);

  // Round-robin search starting one past the last grant.
  always_comb begin
    int              cand;
    logic [NREQ-1:0] cand_oh;
    win_vld = 1'b0;
    win_idx = '0;
    cand    = 0;
    cand_oh = '0;
    for (int k = 0; k < NREQ; k++) begin
      cand    = (int'(last_gnt_q) + 1 + k) % NREQ;
      cand_oh = NREQ'(1) << cand;
      if (!win_vld && (|(req_vld & cand_oh))) begin
        win_vld = 1'b1;
        win_idx = 3'(cand);
      end
    end
  end

  // wr takes precedence when a requester drives both wr and rd.
  assign win_oh    = NREQ'(1) << win_idx;
  assign win_wr    = |(req_wr & win_oh);
  assign win_addr  = 5'(req_addr >> (5 * int'(win_idx)));
  assign win_wdata = 32'(req_wdata >> (32 * int'(win_idx)));

  always_comb begin
    state_d    = state_q;
    last_gnt_d = last_gnt_q;
    gnt_idx_d  = gnt_idx_q;
    cs_d       = cs_q;
    wr_d       = wr_q;
    rd_d       = rd_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    rdata_d    = rdata_q;
    cnt_d      = cnt_q;
    err_d      = err_q;
    is_rd_d    = is_rd_q;
    case (state_q)
      S_IDLE: begin
        if (win_vld) begin
          gnt_idx_d  = win_idx;
          last_gnt_d = win_idx;
          cs_d       = 1'b1;
          wr_d       = win_wr;
          rd_d       = ~win_wr;
          is_rd_d    = ~win_wr;
          addr_d     = win_addr;
          wdata_d    = win_wdata;
          state_d    = win_wr ? S_WRITE : S_READ;
        end
      end
      S_WRITE: begin
        cs_d    = 1'b0;
        wr_d    = 1'b0;
        rd_d    = 1'b0;
        state_d = S_ACK;
      end
      S_READ: begin
        cs_d    = 1'b0;
        wr_d    = 1'b0;
        rd_d    = 1'b0;
        cnt_d   = 8'(TIMEOUT);
        state_d = S_WAIT;
      end
      S_WAIT: begin
        if (uart_rvalid) begin
          rdata_d = uart_rdata;
          err_d   = 1'b0;
          state_d = S_ACK;
        end else if (cnt_q == 8'd1) begin
          rdata_d = 32'hDEADBEEF;
          err_d   = 1'b1;
          state_d = S_ACK;
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end
      S_ACK:   state_d = S_REC;
      // Recovery cycle lets the requester drop req_cs before re-arbitration.
      S_REC:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      state_q    <= S_IDLE;
      last_gnt_q <= 3'(NREQ - 1);
      gnt_idx_q  <= '0;
      cs_q       <= 1'b0;
      wr_q       <= 1'b0;
      rd_q       <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      rdata_q    <= '0;
      cnt_q      <= '0;
      err_q      <= 1'b0;
      is_rd_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      last_gnt_q <= last_gnt_d;
      gnt_idx_q  <= gnt_idx_d;
      cs_q       <= cs_d;
      wr_q       <= wr_d;
      rd_q       <= rd_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      rdata_q    <= rdata_d;
      cnt_q      <= cnt_d;
      err_q      <= err_d;
      is_rd_q    <= is_rd_d;
    end
  end

  assign uart_cs    = cs_q;
  assign uart_wr    = wr_q;
  assign uart_rd    = rd_q;
  assign uart_addr  = addr_q;
  assign uart_wdata = wdata_q;
  assign req_rdata  = rdata_q;
  assign gnt_idx    = gnt_idx_q;
  assign busy       = (state_q != S_IDLE);
  assign req_ack    = (state_q == S_ACK) ? (NREQ'(1) << gnt_idx_q) : '0;
  // err_q is stale after a write, so it is gated with the read flag.
  assign req_err    = (state_q == S_ACK) & is_rd_q & err_q;

endmodule

// File: tb/tb_uart_arbiter.sv
// Testbench for uart_arbiter: directed scenarios with hand-computed
// expectations. A small behavioural UART model answers reads one cycle after
// the strobe and logs written characters.
module tb_uart_arbiter;
  localparam int NREQ    = 4;
  localparam int TIMEOUT = 16;

  logic        clk = 1'b0;
  logic        nreset;
  logic [3:0]  req_cs, req_wr, req_rd;
  logic [19:0] req_addr;
  logic [127:0] req_wdata;
  logic [3:0]  req_ack;
  logic [31:0] req_rdata;
  logic        req_err;
  logic [2:0]  gnt_idx;
  logic        busy;
  logic        uart_cs, uart_wr, uart_rd;
  logic [4:0]  uart_addr;
  logic [31:0] uart_wdata;
  logic [31:0] uart_rdata;
  logic        uart_rvalid;

  int n_checks = 0;
  int n_fail   = 0;
  byte unsigned printed[$];
  logic force_low = 1'b0;

  uart_arbiter #(.NREQ(NREQ), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .nreset(nreset),
    .req_cs(req_cs), .req_wr(req_wr), .req_rd(req_rd),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .req_ack(req_ack), .req_rdata(req_rdata), .req_err(req_err),
    .gnt_idx(gnt_idx), .busy(busy),
    .uart_cs(uart_cs), .uart_wr(uart_wr), .uart_rd(uart_rd),
    .uart_addr(uart_addr), .uart_wdata(uart_wdata),
    .uart_rdata(uart_rdata), .uart_rvalid(uart_rvalid)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] reg_val(input logic [4:0] a);
    case (a)
      5'h14:   return 32'h20;
      5'h00:   return 32'hcc;
      default: return 32'h0;
    endcase
  endfunction

  // Behavioural UART register port.
  always @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      uart_rvalid <= 1'b0;
      uart_rdata  <= 32'h0;
    end else begin
      uart_rvalid <= uart_cs & uart_rd & ~force_low;
      uart_rdata  <= reg_val(uart_addr);
      if (uart_cs && uart_wr) printed.push_back(uart_wdata[7:0]);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_req();
    req_cs = '0; req_wr = '0; req_rd = '0; req_addr = '0; req_wdata = '0;
  endtask

  task automatic drop_req(input int i);
    req_cs = req_cs & ~(4'(1) << i);
  endtask

  task automatic set_req(input int i, input logic wr, input logic rd,
                         input logic [4:0] a, input logic [31:0] d);
    logic [3:0] m;
    m         = 4'(1) << i;
    req_cs    = req_cs | m;
    req_wr    = wr ? (req_wr | m) : (req_wr & ~m);
    req_rd    = rd ? (req_rd | m) : (req_rd & ~m);
    req_addr  = (req_addr & ~(20'h1f << (5 * i))) | (20'(a) << (5 * i));
    req_wdata = (req_wdata & ~(128'hffffffff << (32 * i))) | (128'(d) << (32 * i));
  endtask

  task automatic test_reset();
    clear_req();
    nreset = 1'b1;
    #2 nreset = 1'b0;
    #1;
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rst_busy actual=%0b required=0", busy); end
    n_checks++; if (req_ack !== 4'b0 || req_err !== 1'b0) begin n_fail++; $display("FAIL rst_ack actual=%b/%b required=0000/0", req_ack, req_err); end
    n_checks++; if (req_rdata !== 32'h0 || gnt_idx !== 3'd0) begin n_fail++; $display("FAIL rst_rdata_gnt actual=%h/%0d required=0/0", req_rdata, gnt_idx); end
    n_checks++; if ({uart_cs, uart_wr, uart_rd} !== 3'b000 || uart_addr !== 5'h0 || uart_wdata !== 32'h0) begin
      n_fail++; $display("FAIL rst_uart actual=%b %h %h required=000 0 0", {uart_cs, uart_wr, uart_rd}, uart_addr, uart_wdata); end
    step(); step();
    nreset = 1'b1;
    step();
  endtask

  task automatic test_single_write();
    printed.delete();
    set_req(0, 1'b1, 1'b0, 5'h00, 32'h41);
    step();
    n_checks++; if ({uart_cs, uart_wr, uart_rd} !== 3'b110) begin n_fail++; $display("FAIL wr_strobe actual=%b required=110", {uart_cs, uart_wr, uart_rd}); end
    n_checks++; if (uart_wdata !== 32'h41 || uart_addr !== 5'h0 || gnt_idx !== 3'd0) begin
      n_fail++; $display("FAIL wr_data actual=%h/%h/%0d required=41/0/0", uart_wdata, uart_addr, gnt_idx); end
    n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL wr_busy actual=%0b required=1", busy); end
    step();
    n_checks++; if (req_ack !== 4'b0001 || req_err !== 1'b0) begin n_fail++; $display("FAIL wr_ack actual=%b/%b required=0001/0", req_ack, req_err); end
    n_checks++; if (printed.size() != 1 || printed[0] != 8'h41) begin n_fail++; $display("FAIL wr_print actual_count=%0d required=1 char A", printed.size()); end
    n_checks++; if ({uart_cs, uart_wr} !== 2'b00) begin n_fail++; $display("FAIL wr_strobe_clear actual=%b required=00", {uart_cs, uart_wr}); end
    clear_req();
    step();
    n_checks++; if (busy !== 1'b1 || req_ack !== 4'b0) begin n_fail++; $display("FAIL wr_rec actual=%b/%b required=1/0000", busy, req_ack); end
    step();
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL wr_idle actual=%0b required=0", busy); end
  endtask

  task automatic test_single_read(input logic [4:0] a, input logic [31:0] exp);
    set_req(2, 1'b0, 1'b1, a, 32'h0);
    step();
    n_checks++; if ({uart_cs, uart_wr, uart_rd} !== 3'b101 || uart_addr !== a) begin
      n_fail++; $display("FAIL rd_strobe actual=%b/%h required=101/%h", {uart_cs, uart_wr, uart_rd}, uart_addr, a); end
    n_checks++; if (gnt_idx !== 3'd2) begin n_fail++; $display("FAIL rd_gnt actual=%0d required=2", gnt_idx); end
    step();
    n_checks++; if (uart_rd !== 1'b0 || req_ack !== 4'b0) begin n_fail++; $display("FAIL rd_pulse actual=%b/%b required=0/0000", uart_rd, req_ack); end
    step();
    n_checks++; if (req_ack !== 4'b0100 || req_err !== 1'b0) begin n_fail++; $display("FAIL rd_ack actual=%b/%b required=0100/0", req_ack, req_err); end
    n_checks++; if (req_rdata !== exp) begin n_fail++; $display("FAIL rd_data actual=%h required=%h", req_rdata, exp); end
    clear_req();
    step();
    n_checks++; if (busy !== 1'b1 || req_ack !== 4'b0) begin n_fail++; $display("FAIL rd_rec actual=%b/%b required=1/0000", busy, req_ack); end
    step();
    n_checks++; if (busy !== 1'b0 || req_rdata !== exp) begin n_fail++; $display("FAIL rd_hold actual=%b/%h required=0/%h", busy, req_rdata, exp); end
  endtask

  task automatic test_round_robin();
    byte unsigned exp_chr[5];
    nreset = 1'b0;
    #1 nreset = 1'b1;
    printed.delete();
    for (int i = 0; i < 4; i++) set_req(i, 1'b1, 1'b0, 5'h00, 32'h61 + i);
    for (int k = 0; k < 5; k++) begin
      step();
      n_checks++; if (gnt_idx !== 3'(k % 4) || uart_wr !== 1'b1) begin
        n_fail++; $display("FAIL rr_gnt%0d actual=%0d/%b required=%0d/1", k, gnt_idx, uart_wr, k % 4); end
      step();
      n_checks++; if (req_ack !== (4'(1) << (k % 4))) begin
        n_fail++; $display("FAIL rr_ack%0d actual=%b required=%b", k, req_ack, 4'(1) << (k % 4)); end
      if (k == 4) clear_req();
      step();
      step();
    end
    exp_chr = '{8'h61, 8'h62, 8'h63, 8'h64, 8'h61};
    n_checks++; if (printed.size() != 5) begin n_fail++; $display("FAIL rr_count actual=%0d required=5", printed.size()); end
    for (int k = 0; k < 5 && k < printed.size(); k++) begin
      n_checks++; if (printed[k] != exp_chr[k]) begin n_fail++; $display("FAIL rr_order%0d actual=%h required=%h", k, printed[k], exp_chr[k]); end
    end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rr_idle actual=%0b required=0", busy); end
  endtask

  task automatic test_timeout();
    int cyc;
    bit got;
    force_low = 1'b1;
    set_req(1, 1'b0, 1'b1, 5'h00, 32'h0);
    cyc = 0;
    got = 1'b0;
    for (int c = 1; c <= 40 && !got; c++) begin
      step();
      if (req_ack !== 4'b0) begin got = 1'b1; cyc = c; end
    end
    n_checks++; if (!got || cyc != TIMEOUT + 2) begin n_fail++; $display("FAIL to_cycle actual=%0d required=%0d", cyc, TIMEOUT + 2); end
    n_checks++; if (req_ack !== 4'b0010 || req_err !== 1'b1) begin n_fail++; $display("FAIL to_ack actual=%b/%b required=0010/1", req_ack, req_err); end
    n_checks++; if (req_rdata !== 32'hDEADBEEF) begin n_fail++; $display("FAIL to_data actual=%h required=deadbeef", req_rdata); end
    clear_req();
    force_low = 1'b0;
    step();
    step();
  endtask

  task automatic test_wr_rd_both();
    printed.delete();
    set_req(3, 1'b1, 1'b1, 5'h00, 32'h42);
    step();
    n_checks++; if ({uart_wr, uart_rd} !== 2'b10 || gnt_idx !== 3'd3) begin
      n_fail++; $display("FAIL wrrd_strobe actual=%b/%0d required=10/3", {uart_wr, uart_rd}, gnt_idx); end
    step();
    n_checks++; if (req_ack !== 4'b1000 || req_err !== 1'b0) begin n_fail++; $display("FAIL wrrd_ack actual=%b/%b required=1000/0", req_ack, req_err); end
    n_checks++; if (printed.size() != 1 || printed[0] != 8'h42) begin n_fail++; $display("FAIL wrrd_print actual_count=%0d required=1 char B", printed.size()); end
    clear_req();
    step();
    step();
  endtask

  task automatic test_reset_mid_read();
    force_low = 1'b1;
    set_req(2, 1'b0, 1'b1, 5'h14, 32'h0);
    step(); step(); step();
    n_checks++; if (busy !== 1'b1 || gnt_idx !== 3'd2) begin n_fail++; $display("FAIL mr_wait actual=%b/%0d required=1/2", busy, gnt_idx); end
    #2 nreset = 1'b0;
    #1;
    n_checks++; if (busy !== 1'b0 || gnt_idx !== 3'd0 || req_ack !== 4'b0) begin
      n_fail++; $display("FAIL mr_clear actual=%b/%0d/%b required=0/0/0000", busy, gnt_idx, req_ack); end
    n_checks++; if (req_rdata !== 32'h0 || uart_addr !== 5'h0 || {uart_cs, uart_rd} !== 2'b00) begin
      n_fail++; $display("FAIL mr_outs actual=%h/%h/%b required=0/0/00", req_rdata, uart_addr, {uart_cs, uart_rd}); end
    step();
    n_checks++; if (req_ack !== 4'b0) begin n_fail++; $display("FAIL mr_noack actual=%b required=0000", req_ack); end
    clear_req();
    force_low = 1'b0;
    nreset = 1'b1;
    set_req(0, 1'b1, 1'b0, 5'h00, 32'h30);
    set_req(3, 1'b1, 1'b0, 5'h00, 32'h33);
    step();
    n_checks++; if (gnt_idx !== 3'd0 || uart_wdata !== 32'h30) begin n_fail++; $display("FAIL mr_first actual=%0d/%h required=0/30", gnt_idx, uart_wdata); end
    step();
    n_checks++; if (req_ack !== 4'b0001) begin n_fail++; $display("FAIL mr_ack0 actual=%b required=0001", req_ack); end
    drop_req(0);
    step(); step(); step();
    n_checks++; if (gnt_idx !== 3'd3 || uart_wr !== 1'b1) begin n_fail++; $display("FAIL mr_second actual=%0d/%b required=3/1", gnt_idx, uart_wr); end
    step();
    n_checks++; if (req_ack !== 4'b1000) begin n_fail++; $display("FAIL mr_ack3 actual=%b required=1000", req_ack); end
    clear_req();
    step(); step();
  endtask

  initial begin
    test_reset();
    test_single_write();
    test_single_read(5'h14, 32'h20);
    test_single_read(5'h00, 32'hcc);
    test_round_robin();
    test_timeout();
    test_wr_rd_both();
    test_reset_mid_read();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
